// File: rtl/mult_operand_sequencer.sv
// Multiplier front-end: button qualification, operand capture,
// start/done sequencing with timeout, and product hold for display.
module mult_operand_sequencer #(
  parameter int WIDTH      = 4,
  parameter int STABLE_CNT = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_load,
  input  logic               btn_start,
  input  logic [WIDTH-1:0]   sw,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_product,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               mult_start,
  output logic [2*WIDTH-1:0] result,
  output logic [2:0]         state_dbg,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GOT_A = 3'd1,
    GOT_B = 3'd2,
    RUN   = 3'd3,
    SHOW  = 3'd4
  } state_t;

  localparam logic [15:0] SC_MAX = 16'(STABLE_CNT - 1);
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT - 1);

  // bit 0 is the load button, bit 1 the start button
  logic [1:0]  raw;
  logic [1:0]  acc;
  logic [1:0]  acc_d;
  logic [1:0]  ev;
  logic [15:0] cnt [2];
  logic        ev_load;
  logic        ev_start;

  state_t             state, state_n;
  logic [WIDTH-1:0]   op_a_n, op_b_n;
  logic [2*WIDTH-1:0] result_n;
  logic               err_n, start_n;
  logic [15:0]        tcnt, tcnt_n;

  assign raw      = {btn_start, btn_load};
  assign ev       = acc & ~acc_d;
  assign ev_load  = ev[0];
  assign ev_start = ev[1];

  // Stability filter: a new level is accepted only after it holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      acc_d  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      acc_d <= acc;
      for (int i = 0; i < 2; i++) begin
        if (raw[i] != acc[i]) begin
          if (cnt[i] == SC_MAX) begin
            acc[i] <= raw[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 16'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      err        <= 1'b0;
      mult_start <= 1'b0;
      tcnt       <= '0;
    end else begin
      state      <= state_n;
      op_a       <= op_a_n;
      op_b       <= op_b_n;
      result     <= result_n;
      err        <= err_n;
      mult_start <= start_n;
      tcnt       <= tcnt_n;
    end
  end

  // Next-state decode; load beats start everywhere but RUN
  always_comb begin
    state_n  = state;
    op_a_n   = op_a;
    op_b_n   = op_b;
    result_n = result;
    err_n    = err;
    start_n  = 1'b0;
    tcnt_n   = tcnt;
    unique case (state)
      IDLE: begin
        if (ev_load) begin
          op_a_n  = sw;
          state_n = GOT_A;
        end
      end
      GOT_A: begin
        if (ev_load) begin
          op_b_n  = sw;
          state_n = GOT_B;
        end
      end
      GOT_B: begin
        if (ev_load) begin
          op_a_n  = sw;
          state_n = GOT_A;
        end else if (ev_start) begin
          start_n = 1'b1;
          tcnt_n  = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (mult_done) begin
          result_n = mult_product;
          state_n  = SHOW;
        end else if (tcnt == TO_MAX) begin
          err_n    = 1'b1;
          result_n = '0;
          state_n  = SHOW;
        end else begin
          tcnt_n = tcnt + 16'd1;
        end
      end
      SHOW: begin
        if (ev_load) begin
          err_n   = 1'b0;
          op_a_n  = sw;
          state_n = GOT_A;
        end else if (ev_start) begin
          err_n   = 1'b0;
          start_n = 1'b1;
          tcnt_n  = '0;
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Self-checking bench for mult_operand_sequencer.
// Scoreboard of expected products, checked on each entry to SHOW.
module tb_mult_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_load;
  logic       btn_start;
  logic [3:0] sw;
  logic       mult_done;
  logic [7:0] mult_product;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       mult_start;
  logic [7:0] result;
  logic [2:0] state_dbg;
  logic       err;

  int         checks = 0;
  int         failures = 0;
  int         start_cnt = 0;
  logic [7:0] exp_q [$];

  logic       md_model = 1'b0;
  logic       md_stray = 1'b0;
  logic [7:0] model_prod = '0;
  logic [7:0] stray_prod = '0;
  bit         model_en = 1'b0;
  int         pend = 0;
  logic       ms_prev = 1'b0;
  logic [2:0] st_prev = 3'd0;
  logic [7:0] exp_r;

  assign mult_done    = md_model | md_stray;
  assign mult_product = md_stray ? stray_prod : model_prod;

  mult_operand_sequencer #(
    .WIDTH(4),
    .STABLE_CNT(16),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_load(btn_load),
    .btn_start(btn_start),
    .sw(sw),
    .mult_done(mult_done),
    .mult_product(mult_product),
    .op_a(op_a),
    .op_b(op_b),
    .mult_start(mult_start),
    .result(result),
    .state_dbg(state_dbg),
    .err(err)
  );

  always #5 clk = ~clk;

  // Multiplier model: done pulse five cycles after mult_start
  always begin
    @(posedge clk);
    #1;
    md_model = 1'b0;
    if (rst) begin
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        md_model   = 1'b1;
        model_prod = 8'(op_a) * 8'(op_b);
      end
    end else if (mult_start && model_en) begin
      pend = 5;
    end
  end

  // Monitor: start pulse count/shape and scoreboard on SHOW entry
  always @(negedge clk) begin
    if (!rst) begin
      if (mult_start) begin
        start_cnt++;
        checks++;
        if (ms_prev) begin
          failures++;
          $display("FAIL start_consecutive got=1 exp=0");
        end
      end
      if (state_dbg == 3'd4 && st_prev != 3'd4) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected result=%0d", result);
        end else begin
          exp_r = exp_q.pop_front();
          if (result !== exp_r) begin
            failures++;
            $display("FAIL sb_result got=%0d exp=%0d", result, exp_r);
          end
        end
      end
    end
    ms_prev = mult_start;
    st_prev = state_dbg;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit ld, input bit st, input int hold);
    btn_load  = ld;
    btn_start = st;
    tick(hold);
    btn_load  = 1'b0;
    btn_start = 1'b0;
    tick(20);
  endtask

  task automatic stray(input logic [7:0] p);
    stray_prod = p;
    md_stray   = 1'b1;
    tick(1);
    md_stray   = 1'b0;
    tick(2);
  endtask

  task automatic wait_start(output bit seen);
    int k = 0;
    while (!mult_start && k < 40) begin
      tick(1);
      k++;
    end
    seen = mult_start;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_start got=timeout exp=pulse");
    end
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    rst = 1'b1;
    btn_load = 1'b0;
    btn_start = 1'b0;
    sw = 4'd0;
    tick(3);
    rst = 1'b0;
    repeat (100) begin
      tick(1);
      if ({op_a, op_b, result, mult_start, state_dbg, err} !== '0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_idle got=nonzero exp=0");
    end
    checks++;
    if (start_cnt !== 0) begin
      failures++;
      $display("FAIL reset_start got=%0d exp=0", start_cnt);
    end
  endtask

  task automatic test_glitch();
    sw = 4'd3;
    btn_load = 1'b1;
    tick(15);
    btn_load = 1'b0;
    tick(20);
    checks++;
    if (state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL glitch_state got=%0d exp=0", state_dbg);
    end
    btn_load = 1'b1;
    tick(16);
    btn_load = 1'b0;
    checks++;
    if (state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL hold_early got=%0d exp=0", state_dbg);
    end
    tick(1);
    checks++;
    if (state_dbg !== 3'd1 || op_a !== 4'd3) begin
      failures++;
      $display("FAIL hold_event st=%0d a=%0d exp=1,3", state_dbg, op_a);
    end
    tick(20);
  endtask

  task automatic test_mult();
    int s0;
    sw = 4'd5;
    press(1'b1, 1'b0, 20);
    checks++;
    if (state_dbg !== 3'd2 || op_b !== 4'd5) begin
      failures++;
      $display("FAIL load_b st=%0d b=%0d exp=2,5", state_dbg, op_b);
    end
    model_en = 1'b1;
    exp_q.push_back(8'd15);
    s0 = start_cnt;
    press(1'b0, 1'b1, 20);
    checks++;
    if (start_cnt - s0 !== 1) begin
      failures++;
      $display("FAIL mult_pulses got=%0d exp=1", start_cnt - s0);
    end
    checks++;
    if (state_dbg !== 3'd4 || result !== 8'd15 || err !== 1'b0) begin
      failures++;
      $display("FAIL mult_show st=%0d r=%0d e=%0b exp=4,15,0",
               state_dbg, result, err);
    end
    checks++;
    if (op_a !== 4'd3 || op_b !== 4'd5) begin
      failures++;
      $display("FAIL mult_ops a=%0d b=%0d exp=3,5", op_a, op_b);
    end
  endtask

  task automatic test_rerun();
    int s0 = start_cnt;
    exp_q.push_back(8'd15);
    press(1'b0, 1'b1, 20);
    checks++;
    if (start_cnt - s0 !== 1 || state_dbg !== 3'd4) begin
      failures++;
      $display("FAIL rerun n=%0d st=%0d exp=1,4", start_cnt - s0, state_dbg);
    end
    checks++;
    if (op_a !== 4'd3 || op_b !== 4'd5 || result !== 8'd15) begin
      failures++;
      $display("FAIL rerun_ops a=%0d b=%0d r=%0d exp=3,5,15",
               op_a, op_b, result);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    sw = 4'd3;
    press(1'b1, 1'b0, 20);
    sw = 4'd5;
    press(1'b1, 1'b0, 20);
    model_en = 1'b0;
    exp_q.push_back(8'd0);
    btn_start = 1'b1;
    wait_start(seen);
    btn_start = 1'b0;
    if (seen) begin
      tick(254);
      checks++;
      if (state_dbg !== 3'd3 || err !== 1'b0) begin
        failures++;
        $display("FAIL to_early st=%0d e=%0b exp=3,0", state_dbg, err);
      end
      tick(1);
      checks++;
      if (state_dbg !== 3'd4 || err !== 1'b1 || result !== 8'd0) begin
        failures++;
        $display("FAIL to_fire st=%0d e=%0b r=%0d exp=4,1,0",
                 state_dbg, err, result);
      end
    end
    tick(20);
    sw = 4'd3;
    press(1'b1, 1'b0, 20);
    checks++;
    if (err !== 1'b0 || state_dbg !== 3'd1 || op_a !== 4'd3) begin
      failures++;
      $display("FAIL to_clear e=%0b st=%0d a=%0d exp=0,1,3",
               err, state_dbg, op_a);
    end
  endtask

  task automatic test_reset_run();
    bit seen;
    int s0;
    sw = 4'd5;
    press(1'b1, 1'b0, 20);
    model_en = 1'b1;
    btn_start = 1'b1;
    wait_start(seen);
    btn_start = 1'b0;
    tick(2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({op_a, op_b, result, mult_start, state_dbg, err} !== '0) begin
      failures++;
      $display("FAIL async_rst st=%0d a=%0d b=%0d r=%0d exp=0",
               state_dbg, op_a, op_b, result);
    end
    tick(2);
    rst = 1'b0;
    tick(2);
    s0 = start_cnt;
    press(1'b0, 1'b1, 20);
    tick(10);
    checks++;
    if (state_dbg !== 3'd0 || start_cnt - s0 !== 0) begin
      failures++;
      $display("FAIL post_rst st=%0d n=%0d exp=0,0",
               state_dbg, start_cnt - s0);
    end
  endtask

  task automatic test_stray();
    stray(8'hab);
    checks++;
    if (result !== 8'd0 || state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL stray_idle r=%0d st=%0d exp=0,0", result, state_dbg);
    end
    sw = 4'd3;
    press(1'b1, 1'b0, 20);
    sw = 4'd5;
    press(1'b1, 1'b0, 20);
    exp_q.push_back(8'd15);
    press(1'b0, 1'b1, 20);
    sw = 4'd7;
    press(1'b1, 1'b0, 20);
    stray(8'hab);
    checks++;
    if (result !== 8'd15 || state_dbg !== 3'd1 || op_a !== 4'd7) begin
      failures++;
      $display("FAIL stray_gota r=%0d st=%0d a=%0d exp=15,1,7",
               result, state_dbg, op_a);
    end
  endtask

  task automatic test_simul();
    int s0 = start_cnt;
    sw = 4'd9;
    press(1'b1, 1'b1, 20);
    checks++;
    if (state_dbg !== 3'd2 || op_b !== 4'd9 || start_cnt - s0 !== 0) begin
      failures++;
      $display("FAIL simul st=%0d b=%0d n=%0d exp=2,9,0",
               state_dbg, op_b, start_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_mult();
    test_rerun();
    test_timeout();
    test_reset_run();
    test_stray();
    test_simul();
    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
